// File: rtl/cpu_bus_pkg.sv
// Shared types, default address map and region-table helpers for the CPU bus decoder.
// Region tables are packed {start,end} pairs with slave 0 in the MSBs, bounds inclusive.
package cpu_bus_pkg;

  typedef enum logic [1:0] {IDLE, ACCESS, ERROR, RESP} state_t;

  typedef enum logic [3:0] {
    SLV_RAM,
    SLV_VERSION,
    SLV_IO,
    SLV_UART,
    SLV_NUM_ENTRIES
  } slave_idx_t;

  localparam int DEF_ADDR_W     = 16;
  localparam int DEF_NUM_SLAVES = int'(SLV_NUM_ENTRIES);
  // Widest table the helpers accept: 16 slaves x 2 bounds x 32-bit addresses.
  localparam int MAP_MAX_BITS   = 1024;

  localparam logic [DEF_NUM_SLAVES*2*DEF_ADDR_W-1:0] DEFAULT_REGION_MAP = {
    16'h0000, 16'h2800,
    16'h8000, 16'h80FC,
    16'h9000, 16'h900C,
    16'h9100, 16'h9110
  };

  localparam logic [31:0] DEFAULT_ERR_DATA = 32'hDEAD_BEEF;

  function automatic logic [63:0] pack_region(input logic [31:0] start_addr,
                                              input logic [31:0] end_addr,
                                              input int addr_w);
    logic [63:0] mask;
    mask = (64'h1 << addr_w) - 64'h1;
    return ((64'(start_addr) & mask) << addr_w) | (64'(end_addr) & mask);
  endfunction

  function automatic logic [31:0] region_bound(input logic [MAP_MAX_BITS-1:0] map,
                                               input int num_slaves,
                                               input int idx,
                                               input int addr_w,
                                               input bit want_start);
    int                      lsb;
    logic [MAP_MAX_BITS-1:0] shifted;
    logic [31:0]             mask;
    lsb     = (num_slaves - 1 - idx) * 2 * addr_w + (want_start ? addr_w : 0);
    shifted = map >> lsb;
    mask    = (addr_w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << addr_w) - 32'h1);
    return shifted[31:0] & mask;
  endfunction

  function automatic logic [31:0] region_start(input logic [MAP_MAX_BITS-1:0] map,
                                               input int num_slaves, input int idx,
                                               input int addr_w);
    return region_bound(map, num_slaves, idx, addr_w, 1'b1);
  endfunction

  function automatic logic [31:0] region_end(input logic [MAP_MAX_BITS-1:0] map,
                                             input int num_slaves, input int idx,
                                             input int addr_w);
    return region_bound(map, num_slaves, idx, addr_w, 1'b0);
  endfunction

endpackage

// File: rtl/cpu_bus_region_match.sv
// Combinational address decode: one-hot region select (lowest index wins on overlap),
// hit flag and the address offset from the start of the selected region.
module cpu_bus_region_match
  import cpu_bus_pkg::*;
#(
  parameter int                              ADDR_W     = DEF_ADDR_W,
  parameter int                              NUM_SLAVES = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES*2*ADDR_W-1:0]  REGION_MAP = DEFAULT_REGION_MAP
) (
  input  logic [ADDR_W-1:0]     addr,
  output logic [NUM_SLAVES-1:0] sel,
  output logic                  hit,
  output logic [ADDR_W-1:0]     offset
);

  logic [NUM_SLAVES-1:0] in_range;
  logic [ADDR_W-1:0]     offset_term [NUM_SLAVES];

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_region
    localparam logic [ADDR_W-1:0] START =
      ADDR_W'(region_start(MAP_MAX_BITS'(REGION_MAP), NUM_SLAVES, gi, ADDR_W));
    localparam logic [ADDR_W-1:0] SPAN =
      ADDR_W'(region_end(MAP_MAX_BITS'(REGION_MAP), NUM_SLAVES, gi, ADDR_W)) - START;

    logic [ADDR_W-1:0] rel;

    // start <= addr <= end folds into one unsigned compare of the wrapped offset.
    assign rel          = addr - START;
    assign in_range[gi] = (rel <= SPAN);

    if (gi == 0) begin : g_first
      assign sel[gi] = in_range[gi];
    end else begin : g_rest
      assign sel[gi] = in_range[gi] & ~(|in_range[gi-1:0]);
    end

    assign offset_term[gi] = sel[gi] ? rel : '0;
  end

  always_comb begin
    offset = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      offset = offset | offset_term[i];
    end
  end

  assign hit = |sel;

endmodule

// File: rtl/cpu_bus_decoder.sv
// CPU-bus address decoder with registered slave request, ack wait/timeout and read return.
// Define CPU_BUS_ERR_CAPTURE_EN to add the error address/type/count capture registers.
module cpu_bus_decoder
  import cpu_bus_pkg::*;
#(
  parameter int                             ADDR_W         = DEF_ADDR_W,
  parameter int                             DATA_W         = 32,
  parameter int                             NUM_SLAVES     = DEF_NUM_SLAVES,
  parameter logic [NUM_SLAVES*2*ADDR_W-1:0] REGION_MAP     = DEFAULT_REGION_MAP,
  parameter int                             TIMEOUT_CYCLES = 64,
  parameter logic [DATA_W-1:0]              ERR_DATA       = DATA_W'(DEFAULT_ERR_DATA),
  parameter bit                             LOCAL_ADDR     = 1'b0
) (
  input  logic                         clk_i,
  input  logic                         reset_n_i,
  input  logic                         cpu_req_i,
  input  logic                         cpu_we_i,
  input  logic [ADDR_W-1:0]            cpu_addr_i,
  input  logic [DATA_W-1:0]            cpu_wdata_i,
  output logic                         cpu_busy_o,
  output logic                         cpu_ack_o,
  output logic                         cpu_err_o,
  output logic [DATA_W-1:0]            cpu_rdata_o,
  output logic [NUM_SLAVES-1:0]        slv_sel_o,
  output logic                         slv_we_o,
  output logic [ADDR_W-1:0]            slv_addr_o,
  output logic [DATA_W-1:0]            slv_wdata_o,
`ifdef CPU_BUS_ERR_CAPTURE_EN
  input  logic                         err_clr_i,
  output logic [ADDR_W-1:0]            err_addr_o,
  output logic                         err_type_o,
  output logic [7:0]                   err_count_o,
`endif
  input  logic [NUM_SLAVES-1:0]        slv_ack_i,
  input  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t                  state_reg, state_next;
  logic [NUM_SLAVES-1:0]   sel_reg;
  logic                    we_reg;
  logic [ADDR_W-1:0]       addr_reg;
  logic [DATA_W-1:0]       wdata_reg;
  logic [DATA_W-1:0]       rdata_reg;
  logic                    err_reg;
  logic [CNT_W-1:0]        cnt_reg;

  logic [NUM_SLAVES-1:0]   match_sel;
  logic                    match_hit;
  logic [ADDR_W-1:0]       match_offset;
  logic                    accept;
  logic                    ack_sel;
  logic                    timeout_hit;
  logic [DATA_W-1:0]       rdata_mux;
  logic [DATA_W-1:0]       rdata_term [NUM_SLAVES];

  cpu_bus_region_match #(
    .ADDR_W     (ADDR_W),
    .NUM_SLAVES (NUM_SLAVES),
    .REGION_MAP (REGION_MAP)
  ) u_region_match (
    .addr   (cpu_addr_i),
    .sel    (match_sel),
    .hit    (match_hit),
    .offset (match_offset)
  );

  for (genvar gi = 0; gi < NUM_SLAVES; gi++) begin : g_rdata
    assign rdata_term[gi] = sel_reg[gi] ? slv_rdata_i[gi*DATA_W +: DATA_W] : '0;
  end

  always_comb begin
    rdata_mux = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      rdata_mux = rdata_mux | rdata_term[i];
    end
  end

  assign accept      = (state_reg == IDLE) && cpu_req_i;
  assign ack_sel     = |(slv_ack_i & sel_reg);
  assign timeout_hit = (TIMEOUT_CYCLES > 0) && (cnt_reg == CNT_LAST);

  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE:    if (cpu_req_i) state_next = match_hit ? ACCESS : ERROR;
      ACCESS:  if (ack_sel || timeout_hit) state_next = RESP;
      ERROR:   state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_reg <= IDLE;
      sel_reg   <= '0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      if (accept) begin
        sel_reg   <= match_sel;
        we_reg    <= cpu_we_i;
        addr_reg  <= LOCAL_ADDR ? match_offset : cpu_addr_i;
        wdata_reg <= cpu_wdata_i;
        cnt_reg   <= '0;
      end
      if (state_reg == ACCESS) begin
        if (cnt_reg != CNT_MAX) cnt_reg <= cnt_reg + 1'b1;
        // A selected ack wins over a timeout expiring in the same cycle.
        if (ack_sel) begin
          rdata_reg <= we_reg ? '0 : rdata_mux;
          err_reg   <= 1'b0;
        end else if (timeout_hit) begin
          rdata_reg <= ERR_DATA;
          err_reg   <= 1'b1;
        end
      end
      if (state_reg == ERROR) begin
        rdata_reg <= ERR_DATA;
        err_reg   <= 1'b1;
      end
    end
  end

  assign cpu_busy_o  = (state_reg != IDLE);
  assign cpu_ack_o   = (state_reg == RESP);
  assign cpu_err_o   = (state_reg == RESP) && err_reg;
  assign cpu_rdata_o = rdata_reg;
  assign slv_sel_o   = (state_reg == ACCESS) ? sel_reg : '0;
  assign slv_we_o    = we_reg;
  assign slv_addr_o  = addr_reg;
  assign slv_wdata_o = wdata_reg;

`ifdef CPU_BUS_ERR_CAPTURE_EN
  logic [ADDR_W-1:0] req_addr_reg;
  logic [ADDR_W-1:0] err_addr_reg;
  logic              err_type_reg;
  logic [7:0]        err_count_reg;

  // A held select at an errored response can only mean the slave timed out.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      req_addr_reg  <= '0;
      err_addr_reg  <= '0;
      err_type_reg  <= 1'b0;
      err_count_reg <= '0;
    end else begin
      if (accept) req_addr_reg <= cpu_addr_i;
      if (err_clr_i) begin
        err_addr_reg  <= '0;
        err_type_reg  <= 1'b0;
        err_count_reg <= '0;
      end else if (cpu_err_o) begin
        err_addr_reg <= req_addr_reg;
        err_type_reg <= |sel_reg;
        if (err_count_reg != 8'hFF) err_count_reg <= err_count_reg + 8'd1;
      end
    end
  end

  assign err_addr_o  = err_addr_reg;
  assign err_type_o  = err_type_reg;
  assign err_count_o = err_count_reg;
`endif

endmodule

// File: tb/tb_cpu_bus_decoder.sv
// Randomized bench for cpu_bus_decoder (TIMEOUT_CYCLES=8, LOCAL_ADDR=1) against a
// transaction-level model of the address map, latency and error rules.
module tb_cpu_bus_decoder;

  localparam int ADDR_W     = 16;
  localparam int DATA_W     = 32;
  localparam int NUM_SLAVES = 4;
  localparam int TMO        = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic                         clk = 1'b0;
  logic                         reset_n_i;
  logic                         cpu_req_i;
  logic                         cpu_we_i;
  logic [ADDR_W-1:0]            cpu_addr_i;
  logic [DATA_W-1:0]            cpu_wdata_i;
  logic                         cpu_busy_o;
  logic                         cpu_ack_o;
  logic                         cpu_err_o;
  logic [DATA_W-1:0]            cpu_rdata_o;
  logic [NUM_SLAVES-1:0]        slv_sel_o;
  logic                         slv_we_o;
  logic [ADDR_W-1:0]            slv_addr_o;
  logic [DATA_W-1:0]            slv_wdata_o;
  logic [NUM_SLAVES-1:0]        slv_ack_i;
  logic [NUM_SLAVES*DATA_W-1:0] slv_rdata_i;
`ifdef CPU_BUS_ERR_CAPTURE_EN
  logic                         err_clr_i;
  logic [ADDR_W-1:0]            err_addr_o;
  logic                         err_type_o;
  logic [7:0]                   err_count_o;
  int                           m_err_count;
  logic [ADDR_W-1:0]            m_err_addr;
  logic                         m_err_type;
`endif

  int checks = 0;
  int errors = 0;
  int txn_no = 0;
  int region_lo [NUM_SLAVES] = '{32'h0000, 32'h8000, 32'h9000, 32'h9100};
  int region_hi [NUM_SLAVES] = '{32'h2800, 32'h80FC, 32'h900C, 32'h9110};

  always #5 clk = ~clk;

  cpu_bus_decoder #(
    .TIMEOUT_CYCLES (TMO),
    .LOCAL_ADDR     (1'b1)
  ) dut (
    .clk_i       (clk),
    .reset_n_i   (reset_n_i),
    .cpu_req_i   (cpu_req_i),
    .cpu_we_i    (cpu_we_i),
    .cpu_addr_i  (cpu_addr_i),
    .cpu_wdata_i (cpu_wdata_i),
    .cpu_busy_o  (cpu_busy_o),
    .cpu_ack_o   (cpu_ack_o),
    .cpu_err_o   (cpu_err_o),
    .cpu_rdata_o (cpu_rdata_o),
    .slv_sel_o   (slv_sel_o),
    .slv_we_o    (slv_we_o),
    .slv_addr_o  (slv_addr_o),
    .slv_wdata_o (slv_wdata_o),
`ifdef CPU_BUS_ERR_CAPTURE_EN
    .err_clr_i   (err_clr_i),
    .err_addr_o  (err_addr_o),
    .err_type_o  (err_type_o),
    .err_count_o (err_count_o),
`endif
    .slv_ack_i   (slv_ack_i),
    .slv_rdata_i (slv_rdata_i)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Lowest-numbered region containing the address, -1 when unmapped.
  function automatic int decode(input int a);
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (a >= region_lo[i] && a <= region_hi[i]) return i;
    end
    return -1;
  endfunction

  task automatic check_capture();
`ifdef CPU_BUS_ERR_CAPTURE_EN
    check("err_count", 64'(err_count_o), 64'(m_err_count));
    check("err_addr", 64'(err_addr_o), 64'(m_err_addr));
    check("err_type", 64'(err_type_o), 64'(m_err_type));
`endif
  endtask

  // Starts at a negedge; ends at the negedge of the response cycle (or after the budget).
  task automatic run_txn(input logic we, input logic [ADDR_W-1:0] addr,
                         input logic [DATA_W-1:0] wdata, input logic [DATA_W-1:0] sel_rdata,
                         input int wait_cyc, input int stray_cyc);
    int                    idx, j, exp_cycle, ack_cycle;
    logic                  exp_err;
    logic [DATA_W-1:0]     exp_rdata;
    logic [NUM_SLAVES-1:0] exp_sel, stray_mask;
    logic [DATA_W-1:0]     srd [NUM_SLAVES];

    idx = decode(int'(addr));
    for (int i = 0; i < NUM_SLAVES; i++) srd[i] = $urandom;
    if (idx >= 0) srd[idx] = sel_rdata;
    for (int i = 0; i < NUM_SLAVES; i++) slv_rdata_i[i*DATA_W +: DATA_W] = srd[i];

    if (idx < 0) begin
      exp_err = 1'b1; exp_cycle = 2; exp_rdata = ERR_VAL; exp_sel = '0;
    end else begin
      exp_sel = NUM_SLAVES'(1) << idx;
      if (wait_cyc <= TMO - 1) begin
        exp_err = 1'b0; exp_cycle = wait_cyc + 2; exp_rdata = we ? '0 : srd[idx];
      end else begin
        exp_err = 1'b1; exp_cycle = TMO + 1; exp_rdata = ERR_VAL;
      end
    end
    j = $urandom_range(0, NUM_SLAVES - 1);
    if (idx >= 0 && j == idx) j = (j + 1) % NUM_SLAVES;
    stray_mask = NUM_SLAVES'(1) << j;

    cpu_we_i = we; cpu_addr_i = addr; cpu_wdata_i = wdata; cpu_req_i = 1'b1;
    if (cpu_busy_o) begin
      @(posedge clk); @(negedge clk);
      check("b2b_idle_busy", 64'(cpu_busy_o), 64'(0));
      check("b2b_idle_sel", 64'(slv_sel_o), 64'(0));
    end
    check_capture();
    @(posedge clk);
    ack_cycle = 0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 1) begin
        cpu_req_i = 1'b0;
        check("busy", 64'(cpu_busy_o), 64'(1));
        check("sel", 64'(slv_sel_o), 64'(idx >= 0 ? exp_sel : '0));
        if (idx >= 0) begin
          check("slv_we", 64'(slv_we_o), 64'(we));
          check("slv_addr", 64'(slv_addr_o), 64'(int'(addr) - region_lo[idx]));
          if (we) check("slv_wdata", 64'(slv_wdata_o), 64'(wdata));
        end
      end
      if (cpu_ack_o) begin
        ack_cycle = c;
        break;
      end
      slv_ack_i = '0;
      if (idx >= 0 && c == wait_cyc + 1) slv_ack_i = slv_ack_i | exp_sel;
      if (c == stray_cyc) slv_ack_i = slv_ack_i | stray_mask;
    end
    slv_ack_i = '0;
    check("ack_cycle", 64'(ack_cycle), 64'(exp_cycle));
    check("err", 64'(cpu_err_o), 64'(exp_err));
    check("rdata", 64'(cpu_rdata_o), 64'(exp_rdata));
    check("resp_sel", 64'(slv_sel_o), 64'(0));
`ifdef CPU_BUS_ERR_CAPTURE_EN
    if (exp_err) begin
      if (m_err_count < 255) m_err_count++;
      m_err_addr = addr;
      m_err_type = (idx >= 0);
    end
`endif
    txn_no++;
    $display("txn %0d we=%0b addr=%h wait=%0d ack_cycle=%0d err=%0b rdata=%h",
             txn_no, we, addr, wait_cyc, ack_cycle, cpu_err_o, cpu_rdata_o);
  endtask

  task automatic check_all_zero(input string phase);
    check({phase, "_busy"}, 64'(cpu_busy_o), 64'(0));
    check({phase, "_ack"}, 64'(cpu_ack_o), 64'(0));
    check({phase, "_err"}, 64'(cpu_err_o), 64'(0));
    check({phase, "_rdata"}, 64'(cpu_rdata_o), 64'(0));
    check({phase, "_sel"}, 64'(slv_sel_o), 64'(0));
    check({phase, "_we"}, 64'(slv_we_o), 64'(0));
    check({phase, "_addr"}, 64'(slv_addr_o), 64'(0));
    check({phase, "_wdata"}, 64'(slv_wdata_o), 64'(0));
  endtask

  initial begin
    reset_n_i = 1'b0; cpu_req_i = 1'b0; cpu_we_i = 1'b0; cpu_addr_i = '0;
    cpu_wdata_i = '0; slv_ack_i = '0; slv_rdata_i = '0;
`ifdef CPU_BUS_ERR_CAPTURE_EN
    err_clr_i = 1'b0; m_err_count = 0; m_err_addr = '0; m_err_type = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check_capture();
    reset_n_i = 1'b1;
    @(negedge clk);

    run_txn(1'b0, 16'h9004, '0, 32'h0000_00A5, 0, 0);
    run_txn(1'b1, 16'h0010, 32'h1234_5678, 32'h0, 3, 2);
    run_txn(1'b0, 16'h7000, '0, 32'h0, 0, 1);
    run_txn(1'b0, 16'h9100, '0, 32'h0, 100, 0);
    run_txn(1'b0, 16'h80FC, '0, 32'hCAFE_0001, TMO - 1, 3);

    for (int n = 0; n < 60; n++) begin
      int r, i, a, w, s;
      r = $urandom_range(0, 9);
      i = $urandom_range(0, NUM_SLAVES - 1);
      if (r < 6)       a = region_lo[i] + $urandom_range(0, region_hi[i] - region_lo[i]);
      else if (r == 6) a = region_lo[i];
      else if (r == 7) a = region_hi[i];
      else if (r == 8) a = region_hi[i] + 1;
      else             a = $urandom_range(0, 65535);
      w = $urandom_range(0, 10);
      s = $urandom_range(0, w + 1);
      run_txn(1'($urandom_range(0, 1)), ADDR_W'(a), $urandom, $urandom, w, s);
    end

    // Asynchronous reset in the middle of an access.
    cpu_req_i = 1'b1; cpu_we_i = 1'b1; cpu_addr_i = 16'h8004; cpu_wdata_i = 32'h5555_AAAA;
    if (cpu_busy_o) begin @(posedge clk); @(negedge clk); end
    @(posedge clk); @(negedge clk);
    cpu_req_i = 1'b0;
    check("pre_reset_busy", 64'(cpu_busy_o), 64'(1));
    #2 reset_n_i = 1'b0;
    #1 check_all_zero("async_reset");
    @(posedge clk); @(negedge clk);
    check("reset_no_ack", 64'(cpu_ack_o), 64'(0));
    reset_n_i = 1'b1;
`ifdef CPU_BUS_ERR_CAPTURE_EN
    m_err_count = 0; m_err_addr = '0; m_err_type = 1'b0;
`endif
    @(negedge clk);
    run_txn(1'b0, 16'h9008, '0, 32'h0BAD_F00D, 1, 0);

`ifdef CPU_BUS_ERR_CAPTURE_EN
    // Clear landing on the same edge as a new error: the clear wins.
    run_txn(1'b0, 16'h3000, '0, 32'h0, 0, 0);
    err_clr_i = 1'b1;
    @(posedge clk); @(negedge clk);
    err_clr_i = 1'b0;
    m_err_count = 0; m_err_addr = '0; m_err_type = 1'b0;
    check_capture();
    run_txn(1'b0, 16'hF000, '0, 32'h0, 0, 0);
    run_txn(1'b0, 16'h9110, '0, 32'h0, 50, 0);
`endif
    @(posedge clk); @(negedge clk);
    check_capture();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
